// File: rtl/ifetch_if.sv
// Bus bundle joining ifetch to instruction memory (im_*) and to the sisc core (ir/pc/branch/halt).
interface ifetch_if;
   // Memory side: im_req with im_addr is held until im_ack, and im_data is valid in the im_ack cycle.
   // Core side: ir/pc hold while ir_valid is high, and they transfer on the rising edge where
   // ir_valid && ir_ready. br_taken/br_rel/br_imm/halt only take effect on that edge.
   logic [15:0] im_addr;
   logic        im_req;
   logic        im_ack;
   logic [31:0] im_data;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic [15:0] pc;
   logic        br_taken;
   logic        br_rel;
   logic [15:0] br_imm;
   logic        halt;

   modport master (
      output im_addr, im_req, ir, ir_valid, pc,
      input  im_ack, im_data, ir_ready, br_taken, br_rel, br_imm, halt
   );

   modport slave (
      input  im_addr, im_req, ir, ir_valid, pc,
      output im_ack, im_data, ir_ready, br_taken, br_rel, br_imm, halt
   );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: pulls one word per request from instruction memory into ir.
// Optional macro IFETCH_PREFETCH_EN adds a one-entry prefetch buffer behind ir.
module ifetch (
   input  logic       clk,
   input  logic       rst_f,
   ifetch_if.master   bus,
   output logic [1:0] dbg_state
);
   typedef enum logic [1:0] {S_REQ = 2'd0, S_FULL = 2'd1, S_HALT = 2'd2} state_t;

   state_t      state;
   logic [15:0] fetch_pc;
   logic [15:0] pc_r;
   logic [31:0] ir_r;
   logic        ir_valid_r;
   logic        req_arm;
   logic        consume;
   logic        ack;
   logic [15:0] target;
`ifdef IFETCH_PREFETCH_EN
   logic [31:0] pf_data;
   logic [15:0] pf_pc;
   logic        pf_valid;
`endif

   assign consume = ir_valid_r && bus.ir_ready;
   assign ack     = bus.im_req && bus.im_ack;
   assign target  = bus.br_rel ? (pc_r + 16'd1 + bus.br_imm) : bus.br_imm;

   // req_arm keeps the request low for the reset cycle itself; fetch starts the cycle after release.
`ifdef IFETCH_PREFETCH_EN
   assign bus.im_req = req_arm && ((state == S_REQ) || ((state == S_FULL) && !pf_valid));
`else
   assign bus.im_req = req_arm && (state == S_REQ);
`endif
   assign bus.im_addr  = fetch_pc;
   assign bus.ir       = ir_r;
   assign bus.ir_valid = ir_valid_r;
   assign bus.pc       = pc_r;
   assign dbg_state    = state;

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state      <= S_REQ;
         fetch_pc   <= 16'h0000;
         pc_r       <= 16'h0000;
         ir_r       <= 32'h0000_0000;
         ir_valid_r <= 1'b0;
         req_arm    <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
         pf_data    <= 32'h0000_0000;
         pf_pc      <= 16'h0000;
         pf_valid   <= 1'b0;
`endif
      end else begin
         req_arm <= 1'b1;
         case (state)
            S_REQ: begin
               if (ack) begin
                  ir_r       <= bus.im_data;
                  pc_r       <= fetch_pc;
                  fetch_pc   <= fetch_pc + 16'd1;
                  ir_valid_r <= 1'b1;
                  state      <= S_FULL;
               end
            end
            S_FULL: begin
`ifdef IFETCH_PREFETCH_EN
               if (consume) begin
                  if (bus.br_taken || bus.halt) begin
                     // Redirect or stop: the buffered word and any ack landing now are stale.
                     pf_valid   <= 1'b0;
                     ir_valid_r <= 1'b0;
                     if (bus.br_taken) fetch_pc <= target;
                     state <= bus.halt ? S_HALT : S_REQ;
                  end else if (pf_valid) begin
                     ir_r     <= pf_data;
                     pc_r     <= pf_pc;
                     pf_valid <= 1'b0;
                  end else if (ack) begin
                     ir_r     <= bus.im_data;
                     pc_r     <= fetch_pc;
                     fetch_pc <= fetch_pc + 16'd1;
                  end else begin
                     ir_valid_r <= 1'b0;
                     state      <= S_REQ;
                  end
               end else if (ack) begin
                  pf_data  <= bus.im_data;
                  pf_pc    <= fetch_pc;
                  pf_valid <= 1'b1;
                  fetch_pc <= fetch_pc + 16'd1;
               end
`else
               if (consume) begin
                  ir_valid_r <= 1'b0;
                  if (bus.br_taken) fetch_pc <= target;
                  state <= bus.halt ? S_HALT : S_REQ;
               end
`endif
            end
            S_HALT: begin
               ir_valid_r <= 1'b0;
            end
            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: memory responder and consumer drive the DUT, while a queue-based
// scoreboard checks every presented instruction against a pc-sequence model.
module tb_ifetch;
   logic       clk = 1'b0;
   logic       rst_f;
   logic [1:0] dbg_state;

   ifetch_if bus();

   ifetch dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_pc;
   bit          active = 1'b0;

   // values sampled by the driver at each falling edge
   bit          s_req, s_valid;
   logic [15:0] s_addr, s_pc;
   logic [31:0] s_ir;
   int          wait_cnt = 0;
   int          lat = 1;

   // monitor state
   bit          rst_q, ack_q, rdy_q, halted_q, m_valid;
   logic [15:0] last_pc;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      logic [15:0] lo;
      lo = a * 16'd40503;
      return {a + 16'h1111, lo};
   endfunction

   function automatic bit rbit();
      return $urandom_range(0, 1) == 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string msg);
      checks++;
      failures++;
      $display("FAIL %s", msg);
   endtask

   // One falling edge: sample DUT outputs, then answer memory requests after a random latency.
   task automatic tick();
      @(negedge clk);
      s_req   = bus.im_req;
      s_valid = bus.ir_valid;
      s_addr  = bus.im_addr;
      s_pc    = bus.pc;
      s_ir    = bus.ir;
      bus.im_ack  = 1'b0;
      bus.im_data = $urandom;
      if (!rst_f && s_req) begin
         if (wait_cnt >= lat) begin
            bus.im_ack  = 1'b1;
            bus.im_data = mem_word(s_addr);
            wait_cnt    = 0;
            lat         = $urandom_range(0, 2);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   // Drive consumer inputs; a consume pushes the pc the next instruction must carry.
   task automatic drive(input bit rdy, input bit br, input bit rel, input logic [15:0] imm, input bit hlt);
      bus.ir_ready = rdy;
      bus.br_taken = br;
      bus.br_rel   = rel;
      bus.br_imm   = imm;
      bus.halt     = hlt;
      if (s_valid && rdy && !rst_f) begin
         if (br) model_pc = rel ? model_pc + 16'd1 + imm : imm;
         else    model_pc = model_pc + 16'd1;
         if (!hlt) exp_q.push_back(model_pc);
      end
   endtask

   task automatic release_reset();
      tick();
      rst_f = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      exp_q.delete();
      model_pc = 16'h0000;
      exp_q.push_back(16'h0000);
      lat      = 1;
      wait_cnt = 0;
   endtask

   task automatic do_reset(input int n);
      tick();
      rst_f = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 1; i < n; i++) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      end
      release_reset();
   endtask

   task automatic consume(input bit br, input bit rel, input logic [15:0] imm, input bit hlt);
      bit done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         tick();
         if (s_valid) begin
            drive(1'b1, br, rel, imm, hlt);
            done = 1'b1;
         end else begin
            // branch/halt without ir_valid must be ignored
            drive(rbit(), rbit(), rbit(), 16'($urandom), rbit());
         end
      end
      if (!done) fail_now("consume_timeout: ir_valid not seen within 30 cycles");
   endtask

   task automatic wait_req_check(input string name, input logic [15:0] a);
      bit found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         if (s_req) begin
            found = 1'b1;
            check(name, s_addr, a);
         end
      end
      if (!found) fail_now($sformatf("%s: no im_req within 30 cycles, required addr %0h", name, a));
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         bit rdy;
         tick();
         rdy = ($urandom_range(0, 9) < 6);
         if (s_valid && rdy)
            drive(1'b1, $urandom_range(0, 5) == 0, rbit(), 16'($urandom), 1'b0);
         else
            drive(rdy, rbit(), rbit(), 16'($urandom), rbit());
      end
   endtask

   // Monitor: capture what the DUT sampled at the rising edge.
   always @(posedge clk) begin
      rst_q <= rst_f;
      ack_q <= bus.im_ack && !rst_f;
      rdy_q <= bus.ir_ready;
      if (rst_f) halted_q <= 1'b0;
      else if (m_valid && bus.ir_ready && bus.halt) halted_q <= 1'b1;
   end

   // Monitor: compare DUT outputs after each rising edge against the scoreboard.
   always @(negedge clk) begin
      if (active) begin
         if (rst_q) begin
            m_valid = 1'b0;
            check("rst_ir_valid", bus.ir_valid, 0);
            check("rst_ir", bus.ir, 0);
            check("rst_pc", bus.pc, 0);
         end else begin
            if (ack_q) m_valid = 1'b1;
            else if (m_valid && rdy_q) m_valid = 1'b0;
            check("ir_valid", bus.ir_valid, m_valid);
            if (ack_q) begin
               if (exp_q.size() == 0) begin
                  fail_now($sformatf("sb_empty: instruction at pc %0h with no expected entry", bus.pc));
               end else begin
                  last_pc = exp_q.pop_front();
                  check("pc", bus.pc, last_pc);
                  check("ir", bus.ir, mem_word(last_pc));
               end
            end else if (m_valid) begin
               check("hold_pc", bus.pc, last_pc);
               check("hold_ir", bus.ir, mem_word(last_pc));
            end
            check("req_while_valid", bus.im_req && bus.ir_valid, 0);
            if (halted_q) check("halt_req", {bus.im_req, bus.ir_valid}, 0);
         end
      end
   end

   initial begin
      bit found;
      rst_f        = 1'b1;
      bus.im_ack   = 1'b0;
      bus.im_data  = 32'h0;
      bus.ir_ready = 1'b0;
      bus.br_taken = 1'b0;
      bus.br_rel   = 1'b0;
      bus.br_imm   = 16'h0;
      bus.halt     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      active = 1'b1;
      do_reset(2);

      // first request right after release, ack one cycle later, ir two cycles after release
      tick(); drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      check("first_req", {s_req, s_addr}, {1'b1, 16'h0000});
      tick(); drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      tick(); drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      check("first_ir", {s_valid, s_pc, s_ir}, {1'b1, 16'h0000, 32'h1111_0000});

      // stall in FULL: no request, pc stable
      for (int i = 0; i < 5; i++) begin
         tick(); drive(1'b0, rbit(), rbit(), 16'($urandom), rbit());
         check("stall_req", s_req, 0);
         check("stall_pc", s_pc, model_pc);
      end

      // relative and absolute branches
      consume(1'b1, 1'b0, 16'h0010, 1'b0);
      consume(1'b1, 1'b1, 16'hFFFE, 1'b0);
      wait_req_check("br_rel_addr", 16'h000F);
      consume(1'b1, 1'b0, 16'h0040, 1'b0);
      wait_req_check("br_abs_addr", 16'h0040);

      // sequential wrap at 0xFFFF
      consume(1'b1, 1'b0, 16'hFFFF, 1'b0);
      consume(1'b0, 1'b0, 16'h0, 1'b0);
      wait_req_check("wrap_addr", 16'h0000);

      run_random(400);

      // reset while a request is being acked
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(); drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
         if (s_req) found = 1'b1;
      end
      if (!found) fail_now("rst_ack_setup: no im_req within 30 cycles");
      bus.im_ack  = 1'b1;
      bus.im_data = mem_word(s_addr);
      rst_f       = 1'b1;
      tick(); drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      check("rst_ack_state", {s_valid, s_ir}, 0);
      release_reset();
      wait_req_check("rst_restart_addr", 16'h0000);

      // halt stops fetching until reset
      consume(1'b0, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(); drive(rbit(), rbit(), rbit(), 16'($urandom), rbit());
         check("halt_idle", {s_valid, s_req}, 0);
      end
      do_reset(1);
      wait_req_check("halt_restart_addr", 16'h0000);

      // halt together with branch still halts
      consume(1'b1, 1'b0, 16'h1234, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(); drive(rbit(), rbit(), rbit(), 16'($urandom), rbit());
         check("halt_br_idle", {s_valid, s_req}, 0);
      end
      do_reset(1);

      run_random(400);
      repeat (3) begin
         tick(); drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_f  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 im_addr  output  16  instruction-memory word address.
REQ-004 im_req  output  1  memory read request, held until im_ack.
REQ-005 im_ack  input  1  memory read complete; im_data valid this cycle.
REQ-006 im_data  input  32  instruction word returned by memory.
REQ-007 ir  output  32  registered instruction word presented to sisc ir input.
REQ-008 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-009 ir_ready  input  1  sisc/ctrl accepts ir this cycle; consumed when ir_valid&&ir_ready.
REQ-010 pc  output  16  address of the instruction currently in ir.
REQ-011 br_taken  input  1  redirect fetch, qualified by consume (ir_valid&&ir_ready).
REQ-012 br_rel  input  1  1: target = pc+1+br_imm; 0: target = br_imm.
REQ-013 br_imm  input  16  branch immediate (from ir[15:0]).
REQ-014 halt  input  1  stop fetching after current consume.

Function
REQ-015 FSM states SHALL be REQ, FULL, HALT; internal fetch_pc register holds next address to fetch.
REQ-016 REQ: im_req=1, im_addr=fetch_pc; on im_ack: ir<=im_data, pc<=fetch_pc, fetch_pc<=fetch_pc+1, ir_valid<=1, -> FULL.
REQ-017 Latency: im_ack in cycle N SHALL give ir_valid=1 with new ir in cycle N+1.
REQ-018 FULL: ir, pc, ir_valid SHALL hold until consume; on consume ir_valid<=0 and -> REQ, unless halt.
REQ-019 Consume with br_taken=1: fetch_pc<=target (16-bit, modulo 2^16, br_imm unsigned) before next request.
REQ-020 Consume with halt=1 -> HALT; with halt and br_taken both set, fetch_pc SHALL take the target, then HALT.
REQ-021 HALT: im_req=0, ir_valid=0; only rst_f exits.
REQ-022 br_taken and halt SHALL be ignored when not qualified by consume.
REQ-023 fetch_pc and pc+1 wrap 0xFFFF -> 0x0000 without flag.
REQ-024 im_req SHALL never be asserted while ir_valid=1 unless IFETCH_PREFETCH_EN is defined.

Reset
REQ-025 In any cycle with rst_f=1: state<=REQ, fetch_pc<=0x0000, pc<=0x0000, ir<=0, ir_valid<=0; im_ack in that cycle is ignored.
REQ-026 Reset mid-request SHALL abandon the request; memory is reset by the same rst_f.
REQ-027 First im_req SHALL assert the cycle after rst_f deasserts, im_addr=0x0000.

Configuration
REQ-028 Macro IFETCH_PREFETCH_EN SHALL enable a one-entry prefetch buffer (pf_data, pf_pc, pf_valid).
REQ-029 Defined: in FULL with pf_valid=0, ifetch requests fetch_pc into the buffer; on consume with pf_valid=1, buffer moves to ir/pc same edge (ir_valid stays 1) and, if im_ack is simultaneous, the acked word enters the empty buffer.
REQ-030 Defined: consume with br_taken=1 SHALL clear pf_valid and flush any outstanding request (its im_ack dropped), then fetch target.
REQ-031 Not defined: no buffer, REQ-024 holds, each instruction costs >=2 cycles plus memory latency.

Verification
REQ-032 Reset, memory acks 1 cycle after req with 0x11110000 at addr 0 -> ir=0x11110000, pc=0, ir_valid=1 two cycles after reset release.
REQ-033 ir_ready=0 for 5 cycles in FULL -> ir/pc stable, im_req=0 (macro off); im_req=1 at most 1 entry (macro on).
REQ-034 pc=0x0010, consume with br_taken=1, br_rel=1, br_imm=0xFFFE -> next im_addr=0x000F; br_rel=0, br_imm=0x0040 -> im_addr=0x0040.
REQ-035 fetch_pc=0xFFFF sequential fetch -> pc=0xFFFF then next im_addr=0x0000.
REQ-036 rst_f=1 while im_req=1 and im_ack=1 -> ir_valid=0, ir=0; next im_addr=0x0000.
REQ-037 Consume with halt=1 -> ir_valid=0, im_req=0 for 20 cycles; rst_f pulse restarts fetch at 0x0000.
